// File: rtl/wb_mux_pkg.sv
// ============================================================================
// Module   : wb_mux_pkg
// Brief    : Shared types and constants for the Wishbone slave mux/watchdog.
// Revision : 1.0
// ============================================================================
`default_nettype none

package wb_mux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        TERM = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_UNMAPPED = 2'd1,
        ERR_TIMEOUT  = 2'd2
    } err_t;

    localparam int          ERR_CNT_WIDTH  = 8;
    localparam logic [31:0] C_DEFAULT_READ = 32'hBADFABAC;
    localparam logic [31:0] C_TIMEOUT_READ = 32'hDEADFABC;

endpackage : wb_mux_pkg

`default_nettype wire

// File: rtl/wb_mux_addr_decode.sv
// ============================================================================
// Module   : wb_mux_addr_decode
// Brief    : Aperture comparator; one-hot select with lowest-index priority.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_mux_addr_decode
    import wb_mux_pkg::*;
#(
    parameter int                              N_SLAVES   = 5,
    parameter int                              APERWIDTH  = 17,
    parameter int                              APERSIZE   = 10,
    parameter logic [N_SLAVES*APERWIDTH-1:0]   BASE_ADDRS = {17'h05000, 17'h04000,
                                                             17'h03000, 17'h02000,
                                                             17'h01000}
) (
    input  logic [APERWIDTH-APERSIZE-1:0] i_adr_hi,
    output logic [N_SLAVES-1:0]           o_sel,
    output logic                          o_miss
);

    logic [N_SLAVES-1:0] w_hit;

    for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_hit
        assign w_hit[gi] = (i_adr_hi ==
                            BASE_ADDRS[gi*APERWIDTH+APERSIZE +: APERWIDTH-APERSIZE]);
    end

    // Scan from the top down so the lowest matching index is the last writer.
    always_comb begin
        o_sel = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                o_sel    = '0;
                o_sel[i] = 1'b1;
            end
        end
    end

    assign o_miss = ~|w_hit;

endmodule : wb_mux_addr_decode

`default_nettype wire

// File: rtl/wb_slave_mux_wdt.sv
// ============================================================================
// Module   : wb_slave_mux_wdt
// Brief    : Wishbone slave interconnect with bus watchdog and sticky errors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_slave_mux_wdt
    import wb_mux_pkg::*;
#(
    parameter int                            N_SLAVES           = 5,
    parameter int                            APERWIDTH          = 17,
    parameter int                            APERSIZE           = 10,
    parameter logic [N_SLAVES*APERWIDTH-1:0] BASE_ADDRS         = {17'h05000, 17'h04000,
                                                                   17'h03000, 17'h02000,
                                                                   17'h01000},
    parameter int                            TIMEOUT_CYCLES     = 16,
    parameter logic [31:0]                   DEFAULT_READ_VALUE = C_DEFAULT_READ,
    parameter logic [31:0]                   TIMEOUT_READ_VALUE = C_TIMEOUT_READ
) (
    input  logic                       WBs_CLK_i,
    input  logic                       WBs_RST_i,
    input  logic [APERWIDTH-1:0]       WBs_ADR_i,
    input  logic                       WBs_CYC_i,
    input  logic                       WBs_STB_i,
    input  logic                       WBs_WE_i,
    output logic [31:0]                WBs_DAT_o,
    output logic                       WBs_ACK_o,
    output logic [N_SLAVES-1:0]        WBs_CYC_o,
    input  logic [N_SLAVES-1:0]        WBs_ACK_i,
    input  logic [N_SLAVES*32-1:0]     WBs_DAT_i,
    input  logic                       ERR_CLR_i,
    output logic                       ERR_INTR_o,
    output logic [1:0]                 ERR_TYPE_o,
    output logic [APERWIDTH-1:0]       ERR_ADR_o,
    output logic                       ERR_WE_o,
    output logic [ERR_CNT_WIDTH-1:0]   ERR_CNT_o
);

    localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                     r_state;
    logic [7:0]                 r_cnt;
    err_t                       r_term_err;
    err_t                       r_err_type;
    logic [APERWIDTH-1:0]       r_err_adr;
    logic                       r_err_we;
    logic [ERR_CNT_WIDTH-1:0]   r_err_cnt;

    logic [N_SLAVES-1:0]        w_sel;
    logic                       w_miss;
    logic                       w_slv_ack;
    logic [31:0]                w_rdata;
    logic                       w_start;
    logic                       w_err_unmapped;
    logic                       w_err_timeout;
    logic                       w_err_evt;

    wb_mux_addr_decode #(
        .N_SLAVES   (N_SLAVES),
        .APERWIDTH  (APERWIDTH),
        .APERSIZE   (APERSIZE),
        .BASE_ADDRS (BASE_ADDRS)
    ) u_decode (
        .i_adr_hi (WBs_ADR_i[APERWIDTH-1:APERSIZE]),
        .o_sel    (w_sel),
        .o_miss   (w_miss)
    );

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (w_sel[i]) begin
                w_rdata = WBs_DAT_i[i*32 +: 32];
            end
        end
    end

    assign w_slv_ack      = |(WBs_ACK_i & w_sel);
    assign w_start        = WBs_CYC_i & WBs_STB_i;
    assign w_err_unmapped = (r_state == IDLE) & w_start & w_miss;
    // A slave ACK on the expiry cycle completes normally rather than timing out.
    assign w_err_timeout  = (r_state == BUSY) & WBs_CYC_i & ~w_slv_ack & (r_cnt == C_CNT_LAST);
    assign w_err_evt      = w_err_unmapped | w_err_timeout;

    always_ff @(posedge WBs_CLK_i) begin
        if (!WBs_RST_i) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_term_err <= ERR_NONE;
            r_err_type <= ERR_NONE;
            r_err_adr  <= '0;
            r_err_we   <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_start) begin
                        if (w_miss) begin
                            r_state    <= TERM;
                            r_term_err <= ERR_UNMAPPED;
                        end else begin
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (!WBs_CYC_i || w_slv_ack) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_state    <= TERM;
                        r_term_err <= ERR_TIMEOUT;
                        r_cnt      <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                TERM: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // A new error coinciding with a clear takes precedence over the clear.
            if (w_err_evt) begin
                if (ERR_CLR_i) begin
                    r_err_cnt <= ERR_CNT_WIDTH'(1);
                end else if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
                end
                if (ERR_CLR_i || (r_err_type == ERR_NONE)) begin
                    r_err_type <= w_err_unmapped ? ERR_UNMAPPED : ERR_TIMEOUT;
                    r_err_adr  <= WBs_ADR_i;
                    r_err_we   <= WBs_WE_i;
                end
            end else if (ERR_CLR_i) begin
                r_err_type <= ERR_NONE;
                r_err_adr  <= '0;
                r_err_we   <= 1'b0;
                r_err_cnt  <= '0;
            end
        end
    end

    always_comb begin
        WBs_DAT_o = '0;
        case (r_state)
            BUSY:    WBs_DAT_o = w_rdata;
            TERM:    WBs_DAT_o = (r_term_err == ERR_TIMEOUT) ? TIMEOUT_READ_VALUE
                                                             : DEFAULT_READ_VALUE;
            default: WBs_DAT_o = '0;
        endcase
    end

    assign WBs_ACK_o  = ((r_state == BUSY) & WBs_CYC_i & w_slv_ack) | (r_state == TERM);
    assign WBs_CYC_o  = w_sel & {N_SLAVES{WBs_CYC_i & (r_state == BUSY)}};
    assign ERR_INTR_o = (r_err_type != ERR_NONE);
    assign ERR_TYPE_o = r_err_type;
    assign ERR_ADR_o  = r_err_adr;
    assign ERR_WE_o   = r_err_we;
    assign ERR_CNT_o  = r_err_cnt;

endmodule : wb_slave_mux_wdt

`default_nettype wire

// File: tb/tb_wb_slave_mux_wdt.sv
// ============================================================================
// Module   : tb_wb_slave_mux_wdt
// Brief    : Directed self-checking bench for wb_slave_mux_wdt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_slave_mux_wdt;

    localparam int NS = 5;
    localparam int AW = 17;

    logic           clk;
    logic           rst_n;
    logic [AW-1:0]  adr;
    logic           cyc;
    logic           stb;
    logic           we;
    logic [31:0]    dat_o;
    logic           ack_o;
    logic [NS-1:0]  cyc_o;
    logic [NS-1:0]  slv_ack;
    logic [NS*32-1:0] slv_dat;
    logic           err_clr;
    logic           err_intr;
    logic [1:0]     err_type;
    logic [AW-1:0]  err_adr;
    logic           err_we;
    logic [7:0]     err_cnt;

    int checks = 0;
    int errors = 0;

    wb_slave_mux_wdt dut (
        .WBs_CLK_i  (clk),
        .WBs_RST_i  (rst_n),
        .WBs_ADR_i  (adr),
        .WBs_CYC_i  (cyc),
        .WBs_STB_i  (stb),
        .WBs_WE_i   (we),
        .WBs_DAT_o  (dat_o),
        .WBs_ACK_o  (ack_o),
        .WBs_CYC_o  (cyc_o),
        .WBs_ACK_i  (slv_ack),
        .WBs_DAT_i  (slv_dat),
        .ERR_CLR_i  (err_clr),
        .ERR_INTR_o (err_intr),
        .ERR_TYPE_o (err_type),
        .ERR_ADR_o  (err_adr),
        .ERR_WE_o   (err_we),
        .ERR_CNT_o  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},  32'(ack_o),    32'd0);
        check({tag, "_cyco"}, 32'(cyc_o),    32'd0);
        check({tag, "_dat"},  dat_o,         32'd0);
        check({tag, "_intr"}, 32'(err_intr), 32'd0);
        check({tag, "_type"}, 32'(err_type), 32'd0);
        check({tag, "_adr"},  32'(err_adr),  32'd0);
        check({tag, "_we"},   32'(err_we),   32'd0);
        check({tag, "_cnt"},  32'(err_cnt),  32'd0);
    endtask

    initial begin
        rst_n = 1'b0; adr = '0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        slv_ack = '0; slv_dat = '0; err_clr = 1'b0;

        // Reset state
        step(); step(); step();
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Mapped read to slave0, slave ACKs two cycles after access start
        adr = 17'h01004; cyc = 1'b1; stb = 1'b1; we = 1'b0;
        #1;
        check("rd0_idle_cyco", 32'(cyc_o), 32'd0);
        step(); #1;
        check("rd0_busy_cyco", 32'(cyc_o), 32'h01);
        check("rd0_busy_ack",  32'(ack_o), 32'd0);
        step();
        slv_ack[0] = 1'b1; slv_dat[31:0] = 32'h12345678;
        #1;
        check("rd0_ack", 32'(ack_o), 32'd1);
        check("rd0_dat", dat_o, 32'h12345678);
        step();
        cyc = 1'b0; stb = 1'b0; slv_ack[0] = 1'b0;
        #1;
        check("rd0_after_ack", 32'(ack_o), 32'd0);
        check("rd0_cnt", 32'(err_cnt), 32'd0);

        // Unmapped read
        adr = 17'h07000; cyc = 1'b1; stb = 1'b1; we = 1'b0;
        #1;
        check("um_start_ack", 32'(ack_o), 32'd0);
        step(); #1;
        check("um_ack",  32'(ack_o),    32'd1);
        check("um_cyco", 32'(cyc_o),    32'd0);
        check("um_dat",  dat_o,         32'hBADFABAC);
        check("um_type", 32'(err_type), 32'd1);
        check("um_adr",  32'(err_adr),  32'h07000);
        check("um_intr", 32'(err_intr), 32'd1);
        check("um_cnt",  32'(err_cnt),  32'd1);
        cyc = 1'b0; stb = 1'b0;
        step(); #1;
        check("um_idle_ack", 32'(ack_o), 32'd0);

        // Write to slave3 that never ACKs: forced termination 17 cycles after start
        adr = 17'h04010; cyc = 1'b1; stb = 1'b1; we = 1'b1;
        step(); #1;
        check("to_busy_cyco", 32'(cyc_o), 32'h08);
        for (int i = 2; i <= 16; i++) begin
            step(); #1;
            check("to_wait_ack", 32'(ack_o), 32'd0);
        end
        step(); #1;
        check("to_ack",  32'(ack_o),    32'd1);
        check("to_cyco", 32'(cyc_o),    32'd0);
        check("to_dat",  dat_o,         32'hDEADFABC);
        check("to_type", 32'(err_type), 32'd1);
        check("to_adr",  32'(err_adr),  32'h07000);
        check("to_we",   32'(err_we),   32'd0);
        check("to_cnt",  32'(err_cnt),  32'd2);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        step(); #1;
        check("to_idle_ack", 32'(ack_o), 32'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        #1;
        check("clr_type", 32'(err_type), 32'd0);
        check("clr_adr",  32'(err_adr),  32'd0);
        check("clr_we",   32'(err_we),   32'd0);
        check("clr_cnt",  32'(err_cnt),  32'd0);
        check("clr_intr", 32'(err_intr), 32'd0);

        // Slave2 ACKs on the very cycle the counter expires
        adr = 17'h03008; cyc = 1'b1; stb = 1'b1; we = 1'b0;
        step();
        for (int i = 2; i <= 16; i++) begin
            step();
        end
        slv_ack[2] = 1'b1; slv_dat[95:64] = 32'hCAFEF00D;
        #1;
        check("exp_ack", 32'(ack_o), 32'd1);
        check("exp_dat", dat_o, 32'hCAFEF00D);
        step();
        cyc = 1'b0; stb = 1'b0; slv_ack[2] = 1'b0;
        #1;
        check("exp_idle_ack", 32'(ack_o),    32'd0);
        check("exp_type",     32'(err_type), 32'd0);
        check("exp_cnt",      32'(err_cnt),  32'd0);
        slv_ack[2] = 1'b1;
        #1;
        check("late_ack", 32'(ack_o), 32'd0);
        check("late_dat", dat_o, 32'd0);
        step();
        slv_ack[2] = 1'b0;

        // Master abandons an access in BUSY: no ACK, no error
        adr = 17'h05000; cyc = 1'b1; stb = 1'b1;
        step(); #1;
        check("abort_cyco", 32'(cyc_o), 32'h10);
        cyc = 1'b0; stb = 1'b0;
        step(); #1;
        check("abort_ack", 32'(ack_o), 32'd0);
        check("abort_cnt", 32'(err_cnt), 32'd0);

        // Error counter saturation over 300 unmapped accesses
        for (int i = 0; i < 300; i++) begin
            adr = 17'h07000 + 17'(i); cyc = 1'b1; stb = 1'b1;
            step();
            cyc = 1'b0; stb = 1'b0;
            step();
        end
        #1;
        check("sat_cnt",  32'(err_cnt),  32'd255);
        check("sat_adr",  32'(err_adr),  32'h07000);
        check("sat_type", 32'(err_type), 32'd1);

        // Clear coincident with a new error: the new error wins
        adr = 17'h06004; cyc = 1'b1; stb = 1'b1; we = 1'b1; err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        #1;
        check("clrnew_cnt",  32'(err_cnt),  32'd1);
        check("clrnew_adr",  32'(err_adr),  32'h06004);
        check("clrnew_we",   32'(err_we),   32'd1);
        check("clrnew_type", 32'(err_type), 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        step();

        // Reset in the middle of a BUSY access
        adr = 17'h02000; cyc = 1'b1; stb = 1'b1;
        step(); #1;
        check("rstb_cyco", 32'(cyc_o), 32'h02);
        step();
        rst_n = 1'b0;
        step(); #1;
        check_all_zero("midrst");
        rst_n = 1'b1; cyc = 1'b0; stb = 1'b0;
        slv_ack[1] = 1'b1; slv_dat[63:32] = 32'h0BADBEEF;
        #1;
        check("postrst_ack", 32'(ack_o), 32'd0);
        check("postrst_dat", dat_o, 32'd0);
        step(); #1;
        check("postrst_ack2", 32'(ack_o), 32'd0);
        slv_ack[1] = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_wb_slave_mux_wdt

`default_nettype wire
